// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side drain engine for the dual-bank single-port-RAM FIFO.
// Issues read enables against the FIFO's registered empty flag, absorbs the FIFO's
// one-cycle read latency (fifo_rvalid/fifo_rdata) into a 2-entry in-order skid
// buffer and re-presents the words as a valid/ready stream.
//
// Optional feature macro: FIFO_RD_LAST_EN
//   defined   -> pkt_len input and m_last output exist; m_last marks every
//                pkt_len-th delivered beat (pkt_len=0 behaves as 1).
//   undefined -> no packet framing; everything else is identical.
//
// Stream handshake: a beat transfers on a rising clk edge where m_valid and
// m_ready are both 1. Once m_valid is 1 it stays 1, and m_data stays unchanged,
// until that beat transfers. m_valid never depends on m_ready. fifo_ren does
// depend combinationally on m_ready, because a pop in the current cycle frees
// the credit for the next read.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_ren,
  input  logic                  fifo_rvalid,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic                  err
`ifdef FIFO_RD_LAST_EN
  ,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  output logic                  m_last
`endif
);

  // Occupancy of the output skid buffer. The encoding is the entry count, so
  // it can be added directly to the in-flight read for the credit check.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  occ_t                  occ_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic                  inflight_q;
  logic                  rst_window_q;
  logic                  err_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic                  pop;
  logic                  push;
  logic [2:0]            credit_used;
  logic [2:0]            credit_limit;

  // Stream side: head entry is presented whenever the buffer holds data; all
  // outputs are forced low while reset is asserted.
  always_comb begin
    m_valid      = rst_n && (occ_q != OCC_EMPTY);
    m_data       = m_valid ? head_q : '0;
    pop          = m_valid && m_ready;
    push         = fifo_rvalid && inflight_q;
    // A read may be issued only if buffered words plus the word already in
    // flight, minus the one leaving now, still leave room for one more.
    credit_used  = {1'b0, occ_q} + {2'b00, inflight_q};
    credit_limit = 3'd2 + {2'b00, pop};
    fifo_ren     = rst_n && !fifo_empty && (credit_used < credit_limit);
  end

  assign beat_cnt = cnt_q;
  assign err      = err_q;

  // Occupancy FSM, skid-buffer storage, in-flight tracking, beat counter and
  // sticky protocol error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q        <= OCC_EMPTY;
      head_q       <= '0;
      tail_q       <= '0;
      inflight_q   <= 1'b0;
      rst_window_q <= 1'b1;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      // The read the FIFO actually accepted this cycle returns data next cycle.
      inflight_q   <= fifo_ren && !fifo_empty;
      // The first cycle after reset release may still see a return from a read
      // issued before reset; it is dropped silently.
      rst_window_q <= 1'b0;

      if (pop) begin
        cnt_q <= cnt_q + 1'b1;
      end

      // Return data nobody asked for is discarded and flagged.
      if (fifo_rvalid && !inflight_q && !rst_window_q) begin
        err_q <= 1'b1;
      end

      case (occ_q)
        OCC_EMPTY: begin
          if (push) begin
            head_q <= fifo_rdata;
            occ_q  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            // Head leaves and the new word takes its place.
            head_q <= fifo_rdata;
          end else if (push) begin
            tail_q <= fifo_rdata;
            occ_q  <= OCC_TWO;
          end else if (pop) begin
            occ_q  <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            head_q <= tail_q;
            occ_q  <= OCC_ONE;
          end
          // Credit keeps this from happening; if it does, the word is lost.
          if (push) begin
            err_q <= 1'b1;
          end
        end
        default: begin
          occ_q <= OCC_EMPTY;
        end
      endcase
    end
  end

`ifdef FIFO_RD_LAST_EN
  logic [LEN_WIDTH-1:0] pc_q;
  logic [LEN_WIDTH-1:0] last_idx;

  // Index of the final beat in a packet; a zero length frames every beat.
  always_comb begin
    last_idx = (pkt_len == '0) ? '0 : (pkt_len - LEN_WIDTH'(1));
    m_last   = m_valid && (pc_q == last_idx);
  end

  // Beat-in-packet counter advances on each delivered beat, restarting after last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else if (pop) begin
      pc_q <= m_last ? '0 : (pc_q + LEN_WIDTH'(1));
    end
  end
`else
  // Packet framing is compiled out; the length parameter only needs to be sane.
  if (LEN_WIDTH < 1) begin : g_len_width_invalid
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader. Models the FIFO read port (registered empty
// flag, one-cycle read latency) with a queue, and checks the stream against a
// scoreboard of words written into the FIFO. Build with FIFO_RD_LAST_EN defined
// to also exercise packet framing.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 4;   // narrow counter so wrap-around is reachable
  localparam int LW = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_ren;
  logic          fifo_rvalid = 1'b0;
  logic [DW-1:0] fifo_rdata = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] beat_cnt;
  logic          err;
`ifdef FIFO_RD_LAST_EN
  logic [LW-1:0] pkt_len = 8'd3;
  logic          m_last;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_ren   (fifo_ren),
    .fifo_rvalid(fifo_rvalid),
    .fifo_rdata (fifo_rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .beat_cnt   (beat_cnt),
    .err        (err)
`ifdef FIFO_RD_LAST_EN
    ,
    .pkt_len    (pkt_len),
    .m_last     (m_last)
`endif
  );

  // ---------------- scoreboard / model state ----------------
  logic [DW-1:0] exp_q[$];    // words written to the FIFO, in delivery order
  logic [DW-1:0] fifo_q[$];   // words still stored in the modelled FIFO
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            beats = 0;
  int            mdl_beats = 0;
  int            lasts = 0;
  int            ren_count = 0;
  int            first_ren = -1;
  int            first_valid = -1;
  int            last_beat = -1;
  logic          exp_err = 1'b0;
  logic          spur = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  // values sampled in the most recent cycle, before its clock edge
  logic          s_valid, s_ren, s_err;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic fifo_push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle: sample and check just before the edge, then model the
  // FIFO read port after the edge. Called at posedge+1.
  task automatic cycle();
    logic          acc;
    logic [DW-1:0] w;
`ifdef FIFO_RD_LAST_EN
    int            eff;
`endif
    w = '0;
    #3;
    s_valid = m_valid; s_data = m_data; s_ren = fifo_ren; s_cnt = beat_cnt; s_err = err;
    if (rst_n) begin
      check("beat_cnt", beat_cnt, beats % (1 << CW));
      check("err", err, exp_err);
    end
    if (fifo_empty) check("ren_while_empty", fifo_ren, 0);
    if (prev_stall) begin
      check("stall_valid", m_valid, 1);
      check("stall_data", m_data, prev_data);
    end
    if (!m_valid) check("idle_data", m_data, 0);
`ifdef FIFO_RD_LAST_EN
    if (!m_valid) check("last_idle", m_last, 0);
`endif
    if (m_valid && m_ready) begin
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("beat_data", m_data, exp_q.pop_front());
`ifdef FIFO_RD_LAST_EN
      eff = (pkt_len == 0) ? 1 : int'(pkt_len);
      check("m_last", m_last, ((mdl_beats + 1) % eff) == 0);
      if (m_last) lasts++;
`endif
      mdl_beats++;
      beats++;
      last_beat = cyc;
    end
    if (m_valid && first_valid < 0) first_valid = cyc;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    acc = fifo_ren && !fifo_empty;
    if (acc) begin
      if (fifo_q.size() > 0) w = fifo_q.pop_front();
      ren_count++;
      if (first_ren < 0) first_ren = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    fifo_rvalid = acc || spur;
    fifo_rdata  = acc ? w : (spur ? 8'hA5 : DW'($urandom));
    spur        = 1'b0;
    fifo_empty  = (fifo_q.size() == 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    fifo_empty  = 1'b1;
    fifo_rvalid = 1'b0;
    spur        = 1'b0;
    m_ready     = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    exp_err = 1'b0; beats = 0; mdl_beats = 0; lasts = 0; ren_count = 0;
    first_ren = -1; first_valid = -1; last_beat = -1; prev_stall = 1'b0;
  endtask

  // Run with a ready pattern until the scoreboard drains or the budget expires.
  // mode 0: always ready, 1: toggling 1,0,1,0..., 2: random
  task automatic run_ready(input int mode, input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (i % 2) == 0;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      cycle();
    end
    check("drained", exp_q.size(), 0);
    repeat (2) cycle();
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    int n_words;
    int mode;
    int budget;
    int exp_beats;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] first_word;
    vecs[0] = '{8, 0, 40, 8};     // continuous drain 0x11..0x18
    vecs[1] = '{6, 1, 60, 6};     // push/pop while ready toggles
    vecs[2] = '{12, 2, 200, 12};  // random backpressure
    vecs[3] = '{20, 0, 60, 20};   // beat counter wraps past 2^CW-1
    vecs[4] = '{1, 2, 60, 1};     // single word

    // Reset while the FIFO holds 3 words and the consumer is stalled.
    rst_n = 1'b0;
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) fifo_push(DW'(8'h30 + i));
    repeat (2) cycle();
    check("rst_m_valid", s_valid, 0);
    check("rst_fifo_ren", s_ren, 0);
    check("rst_beat_cnt", s_cnt, 0);
    check("rst_err", s_err, 0);
    check("rst_m_data", s_data, 0);
    do_reset();

    // Table rows.
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int i = 0; i < vecs[r].n_words; i++)
        fifo_push((r == 0) ? DW'(8'h11 + i) : DW'($urandom_range(0, 255)));
      run_ready(vecs[r].mode, vecs[r].budget);
      check("row_beats", beats, vecs[r].exp_beats);
      check("row_beat_cnt", s_cnt, vecs[r].exp_beats % (1 << CW));
      check("row_latency", first_valid - first_ren, 2);
      check("row_ren_idle", s_ren, 0);
      check("row_err", s_err, 0);
      if (vecs[r].mode == 0) check("row_no_gap", last_beat - first_valid, vecs[r].n_words - 1);
    end

    // Backpressure: 4 words, consumer stalled -> exactly two reads, buffer full.
    do_reset();
    for (int i = 0; i < 4; i++) fifo_push(DW'(8'hC0 + i));
    first_word = exp_q[0];
    m_ready = 1'b0;
    repeat (6) cycle();
    check("bp_reads", ren_count, 2);
    check("bp_valid", s_valid, 1);
    check("bp_head", s_data, first_word);
    check("bp_ren_off", s_ren, 0);
    run_ready(0, 20);
    check("bp_beats", beats, 4);
    check("bp_cnt", s_cnt, 4);

    // Spurious return data with nothing in flight sets a sticky error.
    do_reset();
    m_ready = 1'b1;
    repeat (3) cycle();
    spur = 1'b1;
    cycle();            // returns spurious data after this edge
    cycle();            // error captured at this edge
    exp_err = 1'b1;
    repeat (2) cycle();
    check("spur_err", s_err, 1);
    check("spur_discard", s_valid, 0);
    for (int i = 0; i < 3; i++) fifo_push(DW'($urandom_range(0, 255)));
    run_ready(0, 20);
    check("spur_err_sticky", s_err, 1);
    do_reset();
    cycle();
    check("spur_err_cleared", s_err, 0);

    // Return data in the first cycle after reset release is dropped silently.
    rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    m_ready = 1'b1;
    fifo_rvalid = 1'b1;
    fifo_rdata  = 8'h5A;
    repeat (3) cycle();
    check("first_cycle_silent", s_err, 0);
    check("first_cycle_discard", s_valid, 0);

    // Randomized traffic: random FIFO refills and random consumer stalls.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 6) fifo_push(DW'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    run_ready(0, 40);
    check("rand_err", s_err, 0);

    // Reset in the middle of traffic drops the in-flight word and clears state.
    do_reset();
    for (int i = 0; i < 5; i++) fifo_push(DW'(8'h70 + i));
    m_ready = 1'b1;
    repeat (4) cycle();
    check("midop_beats", beats, 2);
    do_reset();
    check("midop_cnt", s_cnt, 0);
    check("midop_valid", s_valid, 0);
    m_ready = 1'b1;
    repeat (4) cycle();
    check("midop_idle", s_valid, 0);

`ifdef FIFO_RD_LAST_EN
    // Packets of 3: last on beats 3 and 6 of 7.
    pkt_len = 8'd3;
    do_reset();
    for (int i = 0; i < 7; i++) fifo_push(DW'(8'h40 + i));
    run_ready(0, 30);
    check("pkt3_lasts", lasts, 2);
    // Zero length: every beat is last.
    pkt_len = 8'd0;
    do_reset();
    for (int i = 0; i < 5; i++) fifo_push(DW'(8'h50 + i));
    run_ready(0, 30);
    check("pkt0_lasts", lasts, 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side drain engine for the dual-bank single-port-RAM FIFO.
- Issues read enables against the FIFO's registered empty flag and absorbs the FIFO's one-cycle read latency (rvalid/rdata).
- Re-presents the data as a valid/ready stream with zero bubbles under continuous backpressure-free flow.
- Sits between the FIFO read port and any downstream stream consumer.

Parameters:
DATA_WIDTH, 8, width of FIFO words and stream data
CNT_WIDTH, 16, width of the delivered-beat counter
LEN_WIDTH, 8, width of packet length (used only with FIFO_RD_LAST_EN)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset; synchronous, active-low
fifo_empty  input  1  FIFO registered empty flag
fifo_ren  output  1  read enable to FIFO
fifo_rvalid  input  1  FIFO read data valid; one cycle after an accepted read
fifo_rdata  input  DATA_WIDTH  FIFO read data, sampled only when fifo_rvalid=1
m_valid  output  1  stream data valid
m_ready  input  1  stream consumer ready
m_data  output  DATA_WIDTH  stream data (head of output buffer)
beat_cnt  output  CNT_WIDTH  count of completed m_valid&&m_ready beats, wraps modulo 2^CNT_WIDTH
err  output  1  sticky protocol error
pkt_len  input  LEN_WIDTH  beats per packet; present only with FIFO_RD_LAST_EN
m_last  output  1  last beat of packet; present only with FIFO_RD_LAST_EN

Behaviour:
- Reset (rst_n=0 at clk edge): buffer emptied, inflight=0, beat_cnt=0, err=0.
- Outputs during and after reset: m_valid=0, m_data=0, fifo_ren=0 combinationally while rst_n=0; m_last=0.
- Output buffer: 2-entry in-order skid buffer. Occupancy FSM has states EMPTY(0), ONE(1), TWO(2). m_valid=1 in ONE or TWO. m_data = head entry; m_data=0 in EMPTY.
- pop = m_valid && m_ready. push = fifo_rvalid && inflight.
- FSM transitions:
  - EMPTY -> ONE on push.
  - ONE -> TWO on push && !pop; ONE -> EMPTY on pop && !push; ONE stays ONE on push && pop (head replaced by new data).
  - TWO -> ONE on pop (push is impossible by credit).
- inflight register: next = fifo_ren && !fifo_empty, i.e. a read the FIFO actually accepted.
- Credit rule: fifo_ren = rst_n && !fifo_empty && (occ + inflight - pop) < 2, evaluated combinationally. Never assert fifo_ren while fifo_empty=1.
- Latency: FIFO word accepted at cycle N, fifo_rvalid at N+1, captured at the N+1 edge, so m_valid is visible at N+2 at the earliest.
- Throughput: with m_ready held at 1 and the FIFO non-empty, one beat per cycle in steady state (occ=1, inflight=1).
- Backpressure: with m_ready=0 the buffer fills to TWO and fifo_ren deasserts. m_data and m_valid stay stable until pop.
- Error cases (err is sticky until reset):
  - fifo_rvalid=1 with inflight=0: data discarded, err set. Exception: the first cycle after rst_n deasserts discards silently.
  - push while occ=2 (should not occur): data dropped, err set.
- beat_cnt increments on every pop and wraps 2^CNT_WIDTH-1 -> 0.
- Mid-operation reset: an in-flight FIFO word is lost from this block's view. The FIFO itself must be reset together with this block.

Optional Feature:
FIFO_RD_LAST_EN
- Defined:
  - pkt_len and m_last ports exist; internal beat-in-packet counter pc (LEN_WIDTH) is reset to 0.
  - m_last = m_valid && (pc == pkt_len-1).
  - On pop: pc <= m_last ? 0 : pc+1.
  - pkt_len is sampled continuously and must be held stable within a packet.
  - pkt_len=0 is treated as 1, so every beat is last.
- Undefined: ports and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with FIFO holding 3 words, m_ready=0 -> m_valid=0, fifo_ren=0, beat_cnt=0, err=0 while rst_n=0.
- Continuous drain: FIFO holds 0x11..0x18, m_ready=1 -> 8 consecutive beats 0x11..0x18 with no gap after the first; first m_valid 2 cycles after first fifo_ren; beat_cnt=8; fifo_ren=0 once empty.
- Backpressure: 4 words queued, m_ready=0 -> exactly 2 reads accepted, state TWO, fifo_ren=0, m_data=first word stable. Release m_ready -> remaining words delivered in order.
- Simultaneous push/pop in ONE with m_ready toggling 1,0,1,0 -> no data loss or duplication; delivered sequence equals FIFO order; err=0.
- Spurious fifo_rvalid with inflight=0 (not first post-reset cycle) -> data discarded, err=1 and stays 1 until reset.
- FIFO_RD_LAST_EN, pkt_len=3, 7 words with m_ready=1 -> m_last high on beats 3 and 6 only. With pkt_len=0 -> m_last on every beat.
